sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-port, time-multiplexed controller for the board's single asynchronous 1M x 16 SRAM (20-bit address, 16-bit DQ, active-low CE/OE/WE/LB/UB).
- Port 0 is the display/frame-reader port and has priority; port 1 is the GIF decoder port, which reads and writes.
- The block sequences every access phase, owns the SRAM pins and the DQ tristate, and bounds port-1 starvation.

Parameters:
ACCESS_CYCLES, 2, clock cycles per SRAM access phase; minimum 2.
STARVE_LIMIT, 4, maximum consecutive port-0 grants while port 1 is waiting.

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
p0_req  in  1  port-0 request; held until p0_gnt
p0_we  in  1  1 = write, 0 = read; sampled at grant
p0_addr  in  20  word address; sampled at grant
p0_wdata  in  16  write data; sampled at grant
p0_be_n  in  2  active-low byte enables {UB,LB}; sampled at grant
p0_gnt  out  1  single-cycle grant pulse
p0_rvalid  out  1  single-cycle read-data-valid pulse
p0_rdata  out  16  read data; valid when p0_rvalid=1
p1_req, p1_we, p1_addr, p1_wdata, p1_be_n, p1_gnt, p1_rvalid, p1_rdata: same widths and meaning for port 1
SRAM_ADDR  out  20  SRAM address
SRAM_DQ  inout  16  SRAM data bus
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  SRAM controls

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - CE_N, OE_N, WE_N, LB_N and UB_N = 1; SRAM_ADDR = 0; SRAM_DQ released (hi-Z).
  - gnt and rvalid = 0 on both ports; rdata = 0; streak counter = 0.
  - Reset mid-access aborts the access: no rvalid is produced and the pins are deasserted the same instant.
- FSM states:
  - IDLE -> ACCESS when any req is asserted.
  - ACCESS runs for ACCESS_CYCLES cycles, counted by cnt 0..ACCESS_CYCLES-1.
  - At the end of ACCESS: go to TURN if the access was a write, else to IDLE.
  - TURN: 1 cycle, DQ released, controls deasserted; -> IDLE.
- Grant:
  - Issued only in IDLE. gnt is combinational: high in the same cycle as req.
  - At that clock edge the block registers addr, we, wdata, be_n and port id.
- Arbitration:
  - Port 0 wins when both request, unless streak == STARVE_LIMIT; then port 1 wins.
  - streak increments on each port-0 grant made while p1_req=1 and saturates at STARVE_LIMIT.
  - streak clears on any port-1 grant, and in any cycle where p1_req=0.
- ACCESS pin behaviour:
  - CE_N = 0; SRAM_ADDR = registered address; LB_N/UB_N = registered be_n.
  - Read: OE_N = 0 for all ACCESS cycles; WE_N = 1; DQ hi-Z.
  - Write: OE_N = 1; DQ driven with wdata for all ACCESS cycles; WE_N = 0 for cnt >= 1. Cycle cnt=0 is address setup, and WE rises before the address changes.
  - Outside ACCESS, all controls = 1 and DQ is hi-Z. SRAM_ADDR holds its last value.
- Read return:
  - DQ is registered at the clock edge ending the last ACCESS cycle.
  - The owning port's rvalid is high for exactly the following cycle; rdata holds until that port's next read completes.
  - Latency: gnt in cycle 0 -> rvalid in cycle ACCESS_CYCLES+1.
- Throughput:
  - Read-to-next-grant: ACCESS_CYCLES+1 cycles.
  - Write-to-next-grant: ACCESS_CYCLES+2 cycles, because of TURN.
  - The rvalid cycle (IDLE) may coincide with a new gnt.
- Requester changes:
  - A requester dropping req before gnt cancels its request without side effects.
  - Input changes after gnt are ignored.
- The block never drives DQ while OE_N = 0.

Test Plan:
1. Reset asserted mid-write (during the WE_N=0 cycle) -> WE_N, CE_N and OE_N go to 1 immediately, DQ goes hi-Z, no rvalid; after reset release, state is IDLE and all controls are 1.
2. p1 writes 0xBEEF to 0x12345 with be_n=00, then p1 reads 0x12345:
   - gnt on cycles 0 and 4 (ACCESS_CYCLES=2: 0 grant, 1-2 ACCESS, 3 TURN).
   - WE_N low only on cycle 2.
   - p1_rvalid on cycle 7 with p1_rdata = 0xBEEF.
3. p0 and p1 both request continuously (STARVE_LIMIT=4) -> grant sequence p0,p0,p0,p0,p1,p0,p0,p0,p0,p1.
4. Byte write 0x00AA to 0x00010 with be_n=10 -> LB_N=0 and UB_N=1 throughout ACCESS; a subsequent read returns the upper byte unchanged and the low byte = 0xAA.
5. p0 read of 0x00000 back-to-back with a p0 read of 0x00001 -> second gnt coincides with the first rvalid (cycle 3); no TURN cycle inserted; DQ never driven.
6. p1_req pulsed for 1 cycle while p0 holds ACCESS -> no p1_gnt and no SRAM activity for p1; streak stays 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port priority arbiter and access sequencer for an async 1M x 16 SRAM
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [19:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic [1:0]  p0_be_n,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [19:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic [1:0]  p1_be_n,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [15:0] p1_rdata,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(ACCESS_CYCLES - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_TURN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [19:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    be_q, be_d;
  logic          port_q, port_d;
  logic          p0_rvalid_q, p0_rvalid_d;
  logic          p1_rvalid_q, p1_rvalid_d;
  logic [15:0]   p0_rdata_q, p0_rdata_d;
  logic [15:0]   p1_rdata_q, p1_rdata_d;

  logic p0_win;
  logic p1_win;
  logic in_access;
  logic dq_oe;

  // Arbitration: port 0 has priority unless port 1 has been passed over STARVE_LIMIT times
  always_comb begin
    p0_win = 1'b0;
    p1_win = 1'b0;
    if (state_q == S_IDLE && !Reset) begin
      if (p0_req && p1_req) begin
        if (streak_q == STREAK_MAX) p1_win = 1'b1;
        else                        p0_win = 1'b1;
      end else if (p0_req) begin
        p0_win = 1'b1;
      end else if (p1_req) begin
        p1_win = 1'b1;
      end
    end
  end

  // Next-state: access sequencing, request capture, read return and starvation streak
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    port_d      = port_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    streak_d    = streak_q;

    case (state_q)
      S_IDLE: begin
        if (p0_win || p1_win) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          port_d  = p1_win;
          addr_d  = p1_win ? p1_addr  : p0_addr;
          we_d    = p1_win ? p1_we    : p0_we;
          wdata_d = p1_win ? p1_wdata : p0_wdata;
          be_d    = p1_win ? p1_be_n  : p0_be_n;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = we_q ? S_TURN : S_IDLE;
          if (!we_q) begin
            if (port_q) begin
              p1_rvalid_d = 1'b1;
              p1_rdata_d  = SRAM_DQ;
            end else begin
              p0_rvalid_d = 1'b1;
              p0_rdata_d  = SRAM_DQ;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!p1_req || p1_win) begin
      streak_d = '0;
    end else if (p0_win && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // State and capture registers; reset aborts any access in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= 2'b11;
      port_q      <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      port_q      <= port_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  // SRAM pins decode straight from registered state so reset releases them at once.
  // WE is held off during cnt=0 (address setup) and rises when ACCESS ends, while
  // the address register is still unchanged.
  always_comb begin
    in_access = (state_q == S_ACCESS);
    dq_oe     = in_access && we_q;
    SRAM_ADDR = addr_q;
    SRAM_CE_N = !in_access;
    SRAM_OE_N = !(in_access && !we_q);
    SRAM_WE_N = !(in_access && we_q && (cnt_q != '0));
    SRAM_LB_N = in_access ? be_q[0] : 1'b1;
    SRAM_UB_N = in_access ? be_q[1] : 1'b1;
  end

  assign SRAM_DQ   = dq_oe ? wdata_q : 16'bz;
  assign p0_gnt    = p0_win;
  assign p1_gnt    = p1_win;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule
